// File: rtl/regfile_wb_sched_pkg.sv
// Shared widths, the default outstanding-load limit and small helpers for
// the register-file write-back scheduler.
package regfile_wb_sched_pkg;

    localparam int REG_IDX_W               = 5;
    localparam int XLEN                    = 32;
    localparam int NUM_REGS                = 32;
    localparam int MAX_OUTSTANDING_DEFAULT = 4;

    typedef struct packed {
        logic                 valid;
        logic [REG_IDX_W-1:0] idx;
        logic [XLEN-1:0]      data;
    } hold_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_HOLD
    } wb_src_e;

    // x0 is hardwired, so its scoreboard bit is never set.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_IDX_W-1:0] idx);
        logic [NUM_REGS-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        v[0]   = 1'b0;
        return v;
    endfunction

endpackage

// File: rtl/regfile_wb_sched.sv
// Register-file write-back scheduler: scoreboard of pending load targets,
// one-entry memory-result holding register and ALU-first write arbitration.
module regfile_wb_sched
    import regfile_wb_sched_pkg::*;
#(
    parameter int MAX_OUTSTANDING = MAX_OUTSTANDING_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 issue_valid,
    input  logic [REG_IDX_W-1:0] issue_rd,
    input  logic [REG_IDX_W-1:0] issue_rs1,
    input  logic [REG_IDX_W-1:0] issue_rs2,
    input  logic                 issue_long,
    output logic                 issue_stall,
    input  logic                 alu_valid,
    input  logic [REG_IDX_W-1:0] alu_idx,
    input  logic [XLEN-1:0]      alu_data,
    input  logic                 mem_valid,
    output logic                 mem_ready,
    input  logic [REG_IDX_W-1:0] mem_idx,
    input  logic [XLEN-1:0]      mem_data,
    output logic                 rf_write_enable,
    output logic [REG_IDX_W-1:0] rf_write_idx,
    output logic [XLEN-1:0]      rf_data,
    output logic [NUM_REGS-1:0]  busy
);

    localparam int              CNT_W   = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    count_q, count_d;
    hold_t               hold_q, hold_d;

    logic    count_full;
    logic    issue_hazard;
    logic    issue_accept;
    logic    long_accept;
    logic    mem_accept;
    logic    hold_drain;
    wb_src_e wb_src;

    // Hazards are judged on registered state only; a result draining this
    // cycle does not release a dependent issue until the next cycle.
    always_comb begin
        count_full   = (count_q == CNT_MAX);
        issue_hazard = busy_q[issue_rs1] | busy_q[issue_rs2] | busy_q[issue_rd]
                     | (issue_long & count_full);
        issue_stall  = issue_valid & ~reset & issue_hazard;
        issue_accept = issue_valid & ~reset & ~issue_hazard;
        long_accept  = issue_accept & issue_long;
        mem_ready    = ~hold_q.valid;
        mem_accept   = mem_valid & ~hold_q.valid & ~reset;
        hold_drain   = hold_q.valid & ~alu_valid & ~reset;
    end

    always_comb begin
        wb_src = WB_NONE;
        if (!reset) begin
            if (alu_valid) begin
                wb_src = WB_ALU;
            end else if (hold_q.valid) begin
                wb_src = WB_HOLD;
            end
        end
    end

    always_comb begin
        rf_write_enable = 1'b0;
        rf_write_idx    = '0;
        rf_data         = '0;
        case (wb_src)
            WB_ALU: begin
                rf_write_enable = 1'b1;
                rf_write_idx    = alu_idx;
                rf_data         = alu_data;
            end
            WB_HOLD: begin
                rf_write_enable = 1'b1;
                rf_write_idx    = hold_q.idx;
                rf_data         = hold_q.data;
            end
            default: ;
        endcase
    end

    // A load target cannot equal the draining index: that register is still
    // busy, so the issue would have stalled.
    always_comb begin
        busy_d  = busy_q;
        count_d = count_q;
        hold_d  = hold_q;
        if (hold_drain) begin
            busy_d       = busy_d & ~reg_onehot(hold_q.idx);
            hold_d.valid = 1'b0;
        end
        if (long_accept) begin
            busy_d = busy_d | reg_onehot(issue_rd);
        end
        if (mem_accept) begin
            hold_d = '{valid: 1'b1, idx: mem_idx, data: mem_data};
        end
        case ({long_accept, hold_drain})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            busy_q  <= '0;
            count_q <= '0;
            hold_q  <= '0;
        end else begin
            busy_q  <= busy_d;
            count_q <= count_d;
            hold_q  <= hold_d;
            assert (!(mem_accept && count_q == '0));
            assert (!(long_accept && count_full));
        end
    end

    assign busy = busy_q;

endmodule

// File: tb/tb_regfile_wb_sched.sv
// Bench for regfile_wb_sched: directed vector table, hand-written corner
// sequences and randomized traffic against an outstanding-load list model.
module tb_regfile_wb_sched;
    import regfile_wb_sched_pkg::*;

    localparam int MAXO = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid, issue_long, issue_stall;
    logic [4:0]  issue_rd, issue_rs1, issue_rs2;
    logic        alu_valid, mem_valid, mem_ready, rf_write_enable;
    logic [4:0]  alu_idx, mem_idx, rf_write_idx;
    logic [31:0] alu_data, mem_data, rf_data, busy;

    int total = 0;
    int bad   = 0;

    // Model: destinations of loads not yet returned, plus the held result.
    int          outq[$];
    bit          m_hv;
    logic [4:0]  m_hidx;
    logic [31:0] m_hdata;

    typedef struct {
        bit          iv;
        logic [4:0]  rd, rs1, rs2;
        bit          lng;
        bit          av;
        logic [4:0]  aidx;
        logic [31:0] adata;
        bit          mv;
        logic [4:0]  midx;
        logic [31:0] mdata;
        bit          e_stall, e_mr, e_we;
        logic [4:0]  e_idx;
        logic [31:0] e_data, e_busy;
    } vec_t;

    localparam int NV = 29;
    vec_t tv[NV];

    always #5 clock = ~clock;

    regfile_wb_sched #(.MAX_OUTSTANDING(MAXO)) dut (
        .clock           (clock),
        .reset           (reset),
        .issue_valid     (issue_valid),
        .issue_rd        (issue_rd),
        .issue_rs1       (issue_rs1),
        .issue_rs2       (issue_rs2),
        .issue_long      (issue_long),
        .issue_stall     (issue_stall),
        .alu_valid       (alu_valid),
        .alu_idx         (alu_idx),
        .alu_data        (alu_data),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_idx         (mem_idx),
        .mem_data        (mem_data),
        .rf_write_enable (rf_write_enable),
        .rf_write_idx    (rf_write_idx),
        .rf_data         (rf_data),
        .busy            (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0; issue_long = 0;
        alu_valid = 0; alu_idx = 0; alu_data = 0;
        mem_valid = 0; mem_idx = 0; mem_data = 0;
    endtask

    task automatic load(input logic [4:0] rd);
        idle();
        issue_valid = 1; issue_rd = rd; issue_long = 1;
    endtask

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        foreach (outq[i]) b[outq[i]] = 1'b1;
        if (m_hv) b[m_hidx] = 1'b1;
        b[0] = 1'b0;
        return b;
    endfunction

    // Called at the negative edge with inputs stable: check, clock, update.
    task automatic step();
        logic [31:0] b;
        int          cnt;
        bit          e_stall, e_we;
        logic [4:0]  e_idx;
        logic [31:0] e_data;
        int          qi[$];
        b       = model_busy();
        cnt     = outq.size() + (m_hv ? 1 : 0);
        e_stall = !reset && issue_valid &&
                  (b[issue_rs1] || b[issue_rs2] || b[issue_rd] || (issue_long && cnt == MAXO));
        e_we    = !reset && (alu_valid || m_hv);
        e_idx   = alu_valid ? alu_idx : m_hidx;
        e_data  = alu_valid ? alu_data : m_hdata;
        chk("model_busy", busy, b);
        chk("model_stall", 32'(issue_stall), 32'(e_stall));
        chk("model_mem_ready", 32'(mem_ready), 32'(!m_hv));
        chk("model_we", 32'(rf_write_enable), 32'(e_we));
        if (e_we) begin
            chk("model_widx", 32'(rf_write_idx), 32'(e_idx));
            chk("model_wdata", rf_data, e_data);
        end
        $display("cyc t=%0t rst=%0b iv=%0b stall=%0b we=%0b idx=%0d data=%h busy=%h",
                 $time, reset, issue_valid, issue_stall, rf_write_enable, rf_write_idx, rf_data, busy);
        @(posedge clock);
        if (reset) begin
            outq.delete();
            m_hv = 0;
        end else begin
            if (mem_valid && !m_hv) begin
                qi = outq.find_first_index(x) with (x == int'(mem_idx));
                if (qi.size() > 0) outq.delete(qi[0]);
                m_hv = 1; m_hidx = mem_idx; m_hdata = mem_data;
            end else if (m_hv && !alu_valid) begin
                m_hv = 0;
            end
            if (issue_valid && !e_stall && issue_long) outq.push_back(int'(issue_rd));
        end
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        @(negedge clock);
        step();
        reset = 0;
    endtask

    initial begin
        // iv rd rs1 rs2 lng | av aidx adata | mv midx mdata | stall mr we widx wdata busy
        tv[0]  = '{1,1,0,0,1, 0,0,0, 0,0,0,            0,1,0,0,0,            32'h0};
        tv[1]  = '{1,2,0,0,1, 0,0,0, 0,0,0,            0,1,0,0,0,            32'h2};
        tv[2]  = '{1,3,0,0,1, 0,0,0, 0,0,0,            0,1,0,0,0,            32'h6};
        tv[3]  = '{1,4,0,0,1, 0,0,0, 0,0,0,            0,1,0,0,0,            32'hE};
        tv[4]  = '{1,5,0,0,1, 0,0,0, 0,0,0,            1,1,0,0,0,            32'h1E};
        tv[5]  = '{1,5,0,0,1, 0,0,0, 1,1,32'h11,       1,1,0,0,0,            32'h1E};
        tv[6]  = '{1,5,0,0,1, 0,0,0, 0,0,0,            1,0,1,1,32'h11,       32'h1E};
        tv[7]  = '{1,5,0,0,1, 0,0,0, 0,0,0,            0,1,0,0,0,            32'h1C};
        tv[8]  = '{0,0,0,0,0, 0,0,0, 1,2,32'h22,       0,1,0,0,0,            32'h3C};
        tv[9]  = '{0,0,0,0,0, 0,0,0, 0,0,0,            0,0,1,2,32'h22,       32'h3C};
        tv[10] = '{0,0,0,0,0, 0,0,0, 1,3,32'h33,       0,1,0,0,0,            32'h38};
        tv[11] = '{1,9,0,0,1, 0,0,0, 0,0,0,            0,0,1,3,32'h33,       32'h38};
        tv[12] = '{0,0,0,0,0, 0,0,0, 0,0,0,            0,1,0,0,0,            32'h230};
        tv[13] = '{0,0,0,0,0, 0,0,0, 1,4,32'h44,       0,1,0,0,0,            32'h230};
        tv[14] = '{0,0,0,0,0, 0,0,0, 0,0,0,            0,0,1,4,32'h44,       32'h230};
        tv[15] = '{0,0,0,0,0, 0,0,0, 1,5,32'h55,       0,1,0,0,0,            32'h220};
        tv[16] = '{0,0,0,0,0, 0,0,0, 0,0,0,            0,0,1,5,32'h55,       32'h220};
        tv[17] = '{0,0,0,0,0, 0,0,0, 1,9,32'h99,       0,1,0,0,0,            32'h200};
        tv[18] = '{0,0,0,0,0, 0,0,0, 0,0,0,            0,0,1,9,32'h99,       32'h200};
        tv[19] = '{1,0,0,0,1, 0,0,0, 0,0,0,            0,1,0,0,0,            32'h0};
        tv[20] = '{0,0,0,0,0, 0,0,0, 0,0,0,            0,1,0,0,0,            32'h0};
        tv[21] = '{0,0,0,0,0, 0,0,0, 1,0,32'hABCD,     0,1,0,0,0,            32'h0};
        tv[22] = '{0,0,0,0,0, 0,0,0, 0,0,0,            0,0,1,0,32'hABCD,     32'h0};
        tv[23] = '{1,11,0,0,1, 0,0,0, 0,0,0,           0,1,0,0,0,            32'h0};
        tv[24] = '{1,12,0,0,1, 0,0,0, 0,0,0,           0,1,0,0,0,            32'h800};
        tv[25] = '{1,13,0,0,1, 0,0,0, 0,0,0,           0,1,0,0,0,            32'h1800};
        tv[26] = '{1,14,0,0,1, 0,0,0, 0,0,0,           0,1,0,0,0,            32'h3800};
        tv[27] = '{1,15,0,0,1, 0,0,0, 0,0,0,           1,1,0,0,0,            32'h7800};
        tv[28] = '{1,15,0,0,1, 1,0,32'h77, 0,0,0,      1,1,1,0,32'h77,       32'h7800};

        idle();
        reset = 1;
        m_hv = 0;
        repeat (2) @(posedge clock);
        #1;
        // Issue while reset is high must neither stall nor update state.
        load(5'd3);
        @(negedge clock);
        chk("rst_stall_low", 32'(issue_stall), 32'd0);
        step();
        reset = 0;
        idle();
        @(negedge clock);
        chk("rst_busy", busy, 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("rst_we", 32'(rf_write_enable), 32'd0);
        step();

        for (int i = 0; i < NV; i++) begin
            issue_valid = tv[i].iv;  issue_rd = tv[i].rd; issue_rs1 = tv[i].rs1;
            issue_rs2 = tv[i].rs2;   issue_long = tv[i].lng;
            alu_valid = tv[i].av;    alu_idx = tv[i].aidx; alu_data = tv[i].adata;
            mem_valid = tv[i].mv;    mem_idx = tv[i].midx; mem_data = tv[i].mdata;
            @(negedge clock);
            chk($sformatf("vec%0d_stall", i), 32'(issue_stall), 32'(tv[i].e_stall));
            chk($sformatf("vec%0d_mem_ready", i), 32'(mem_ready), 32'(tv[i].e_mr));
            chk($sformatf("vec%0d_we", i), 32'(rf_write_enable), 32'(tv[i].e_we));
            chk($sformatf("vec%0d_busy", i), busy, tv[i].e_busy);
            if (tv[i].e_we) begin
                chk($sformatf("vec%0d_widx", i), 32'(rf_write_idx), 32'(tv[i].e_idx));
                chk($sformatf("vec%0d_wdata", i), rf_data, tv[i].e_data);
            end
            step();
        end

        // Dependent ALU issue waits for the load result to drain.
        do_reset();
        load(5'd5);
        @(negedge clock);
        step();
        idle();
        issue_valid = 1; issue_rd = 5'd10; issue_rs1 = 5'd5;
        for (int k = 0; k < 5; k++) begin
            mem_valid = (k == 2); mem_idx = 5'd5; mem_data = 32'h5555;
            @(negedge clock);
            chk($sformatf("dep_stall_c%0d", k), 32'(issue_stall), (k < 4) ? 32'd1 : 32'd0);
            step();
        end

        // ALU writes pre-empt a held memory result for three cycles.
        do_reset();
        load(5'd7);
        @(negedge clock);
        step();
        for (int c = 1; c <= 5; c++) begin
            idle();
            alu_valid = (c <= 3); alu_idx = 5'd3; alu_data = 32'h300 + c;
            mem_valid = (c == 1); mem_idx = 5'd7; mem_data = 32'hDEADBEEF;
            @(negedge clock);
            chk($sformatf("prio_mem_ready_c%0d", c), 32'(mem_ready), (c == 1 || c == 5) ? 32'd1 : 32'd0);
            chk($sformatf("prio_we_c%0d", c), 32'(rf_write_enable), (c <= 4) ? 32'd1 : 32'd0);
            if (c <= 3) begin
                chk($sformatf("prio_idx_c%0d", c), 32'(rf_write_idx), 32'd3);
                chk($sformatf("prio_data_c%0d", c), rf_data, 32'h300 + c);
            end else if (c == 4) begin
                chk("prio_idx_c4", 32'(rf_write_idx), 32'd7);
                chk("prio_data_c4", rf_data, 32'hDEADBEEF);
            end
            step();
        end

        // Reset while a result is held discards it.
        do_reset();
        load(5'd8);
        @(negedge clock);
        step();
        idle();
        mem_valid = 1; mem_idx = 5'd8; mem_data = 32'hCAFE;
        alu_valid = 1; alu_idx = 5'd1; alu_data = 32'h1;
        @(negedge clock);
        step();
        idle();
        reset = 1;
        issue_valid = 1; issue_rd = 5'd20; issue_rs1 = 5'd8;
        @(negedge clock);
        chk("rstmid_busy_before", busy, 32'h100);
        chk("rstmid_stall", 32'(issue_stall), 32'd0);
        chk("rstmid_we", 32'(rf_write_enable), 32'd0);
        step();
        reset = 0;
        idle();
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            chk($sformatf("rstmid_busy_after%0d", k), busy, 32'd0);
            chk($sformatf("rstmid_mem_ready%0d", k), 32'(mem_ready), 32'd1);
            chk($sformatf("rstmid_we_after%0d", k), 32'(rf_write_enable), 32'd0);
            step();
        end

        // Randomized traffic; memory results only name outstanding loads.
        for (int n = 0; n < 3000; n++) begin
            idle();
            reset       = ($urandom_range(0, 199) == 0);
            issue_valid = $urandom_range(0, 1);
            issue_rd    = 5'($urandom_range(0, 7));
            issue_rs1   = 5'($urandom_range(0, 7));
            issue_rs2   = 5'($urandom_range(0, 7));
            issue_long  = $urandom_range(0, 1);
            alu_valid   = ($urandom_range(0, 2) == 0);
            alu_idx     = 5'($urandom);
            alu_data    = $urandom;
            if (outq.size() > 0 && $urandom_range(0, 1) == 1) begin
                mem_valid = 1;
                mem_idx   = 5'(outq[$urandom_range(0, outq.size() - 1)]);
                mem_data  = $urandom;
            end
            @(negedge clock);
            step();
        end
        reset = 0;
        idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
